parking_checkin: RTL and testbench
==================================

// Module: parking_checkin
// PURPOSE
//  Entry-side slot allocator for the parking system, upstream of checkout.
//  - Keeps the free-running time base (timer).
//  - On each car arrival, grants the lowest free slot and stamps its entry time.
//  - Publishes entry times p1..p6 and per-slot occupancy for checkout to compute use time and fee.
//  - Frees a slot when checkout reports the car has left.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per timer unit (1 s at 100 MHz); >=2; bench uses 4
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  checkin_btn   in   1   arrival button level (already debounced), may be held many cycles
//  release_valid in   1   1-cycle pulse: slot release_slot vacated
//  release_slot  in   4   slot to free, valid 1..6
//  timer         out  11  time-unit counter, wraps 2047->0
//  p1..p6        out  11  entry timestamp of slot 1..6
//  occupied      out  6   bit k-1 = slot k in use
//  full          out  1   occupied == 6'b111111 (combinational from occupied)
//  checkin_ack   out  1   1-cycle pulse: slot granted
//  checkin_slot  out  4   granted slot 1..6; holds until next grant
//  checkin_rej   out  1   1-cycle pulse: arrival while full
//  release_err   out  1   1-cycle pulse: release of free or out-of-range slot
// BEHAVIOUR
//  Reset (async assert, sync deassert by next clk):
//   - All outputs 0.
//   - Prescaler 0; FSM in IDLE.
//  Time base:
//   - Prescaler counts 0..TICK_DIV-1; at terminal count timer<=timer+1 (mod 2048) and prescaler<=0.
//   - First increment occurs TICK_DIV cycles after reset release.
//  Edge detect:
//   - btn_q <= checkin_btn each clk.
//   - rise = checkin_btn & ~btn_q.
//  FSM states: IDLE, GRANT, WAIT_LOW.
//   - IDLE: on rise -> GRANT; otherwise stay.
//   - GRANT (exactly 1 cycle):
//     - If any slot free: pick k = lowest index with occupied[k-1]==0; set occupied[k-1];
//       pk<=timer (value present in this cycle); checkin_slot<=k; checkin_ack=1.
//     - Else: checkin_rej=1; nothing else changes.
//     - Always -> WAIT_LOW.
//   - WAIT_LOW: stay while checkin_btn==1; -> IDLE when checkin_btn==0.
//     - Holding the button yields exactly one grant.
//     - Press latency: ack/rej registered, visible the cycle after GRANT, i.e. 2 clk after the
//       first high sample of checkin_btn.
//  Release, any FSM state:
//   - release_valid with slot k in 1..6 and occupied[k-1]==1: clear occupied[k-1] next cycle.
//   - pk is NOT cleared; it holds the last entry stamp until slot k is granted again.
//   - Any other release_valid (k==0, k>6, or slot already free): no state change; release_err=1 next cycle.
//  Simultaneous release + GRANT in same cycle:
//   - Allocation uses occupancy before the release; the freed slot cannot be granted that cycle.
//   - Both updates apply: granted bit set, released bit cleared.
//   - If full before the release: checkin_rej=1 and the release still takes effect.
//  Reset mid-operation: any pending GRANT is abandoned, all occupancy lost, timer restarts at 0.
//  Timer wrap: stamps are raw 11-bit values; downstream handles wrap via modulo-2048 subtraction.
// TESTING (TICK_DIV=4)
//  1. Reset release, no input, 20 clk -> timer=5 (increments at clk 4,8,12,16,20), all p*=0, occupied=0.
//  2. Press btn when timer=3 -> checkin_ack 1 cycle, checkin_slot=1, p1=3, occupied=000001;
//     holding btn 50 clk gives no second ack.
//  3. Six presses, then a seventh -> slots granted 1..6, full=1; seventh gives checkin_rej, occupied unchanged.
//  4. Full; release slot 3 on the same clk as GRANT -> checkin_rej=1, occupied=111011;
//     next press grants slot 3 with p3 = current timer.
//  5. release_slot=0, 7, and free slot 5 -> release_err pulse each time, occupied unchanged.
//  6. Run to timer=2047 -> wraps to 0 after 4 clk; assert rst_n=0 between clk edges while in
//     GRANT -> outputs 0 immediately, no ack.

Source files
------------

// File: rtl/parking_checkin_if.sv
// Entry-side parking bus: arrival button and release requests in,
// time base, entry stamps, occupancy and grant/reject/error pulses out.
interface parking_checkin_if;
  logic        checkin_btn;
  logic        release_valid;
  logic [3:0]  release_slot;
  logic [10:0] timer;
  logic [10:0] p1;
  logic [10:0] p2;
  logic [10:0] p3;
  logic [10:0] p4;
  logic [10:0] p5;
  logic [10:0] p6;
  logic [5:0]  occupied;
  logic        full;
  logic        checkin_ack;
  logic [3:0]  checkin_slot;
  logic        checkin_rej;
  logic        release_err;

  // Driver side: the arrival button and the checkout release path.
  modport master (
    output checkin_btn, release_valid, release_slot,
    input  timer, p1, p2, p3, p4, p5, p6, occupied, full,
    input  checkin_ack, checkin_slot, checkin_rej, release_err
  );

  // Allocator side.
  modport slave (
    input  checkin_btn, release_valid, release_slot,
    output timer, p1, p2, p3, p4, p5, p6, occupied, full,
    output checkin_ack, checkin_slot, checkin_rej, release_err
  );
endinterface

// File: rtl/parking_checkin.sv
// Parking entry allocator: free-running time base, lowest-free-slot grant on each
// button press with entry timestamp, and slot release driven by checkout.
module parking_checkin #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  parking_checkin_if.slave   bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_LOW} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [10:0]    timer_q, timer_d;
  logic           btn_q;
  logic [5:0]     occ_q, occ_d;
  logic [3:0]     slot_q, slot_d;
  logic           ack_q, ack_d;
  logic           rej_q, rej_d;
  logic           rel_err_q, rel_err_d;

  logic           rise;
  logic           grant_now;
  logic           free_found;
  logic [2:0]     free_idx;
  logic [5:0]     gnt_mask;
  logic [5:0]     rel_mask;
  logic           rel_ok;
  logic [10:0]    stamps [6];

  assign rise = bus.checkin_btn & ~btn_q;

  // Time base
  always_comb begin
    presc_d = presc_q + PW'(1);
    timer_d = timer_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      timer_d = timer_q + 11'd1;
    end
  end

  // Lowest free slot, judged on occupancy before any same-cycle release.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (!occ_q[k]) begin
        free_found = 1'b1;
        free_idx   = 3'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_now = 1'b0;
    ack_d     = 1'b0;
    rej_d     = 1'b0;
    slot_d    = slot_q;
    case (state_q)
      IDLE: begin
        if (rise) state_d = GRANT;
      end
      GRANT: begin
        grant_now = 1'b1;
        if (free_found) begin
          ack_d  = 1'b1;
          slot_d = {1'b0, free_idx} + 4'd1;
        end else begin
          rej_d = 1'b1;
        end
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.checkin_btn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_slot
      logic [10:0] stamp_q;

      assign gnt_mask[gi] = grant_now & free_found & (free_idx == 3'(gi));
      assign rel_mask[gi] = bus.release_valid & (bus.release_slot == 4'(gi + 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stamp_q <= '0;
        end else if (gnt_mask[gi]) begin
          stamp_q <= timer_q;
        end
      end

      assign stamps[gi] = stamp_q;
    end
  endgenerate

  // A release only counts if it names an occupied slot 1..6; anything else is an error.
  assign rel_ok    = |(rel_mask & occ_q);
  assign rel_err_d = bus.release_valid & ~rel_ok;
  assign occ_d     = (occ_q & ~rel_mask) | gnt_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      timer_q   <= '0;
      btn_q     <= 1'b0;
      occ_q     <= '0;
      slot_q    <= '0;
      ack_q     <= 1'b0;
      rej_q     <= 1'b0;
      rel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      timer_q   <= timer_d;
      btn_q     <= bus.checkin_btn;
      occ_q     <= occ_d;
      slot_q    <= slot_d;
      ack_q     <= ack_d;
      rej_q     <= rej_d;
      rel_err_q <= rel_err_d;
    end
  end

  assign bus.timer        = timer_q;
  assign bus.p1           = stamps[0];
  assign bus.p2           = stamps[1];
  assign bus.p3           = stamps[2];
  assign bus.p4           = stamps[3];
  assign bus.p5           = stamps[4];
  assign bus.p6           = stamps[5];
  assign bus.occupied     = occ_q;
  assign bus.full         = &occ_q;
  assign bus.checkin_ack  = ack_q;
  assign bus.checkin_slot = slot_q;
  assign bus.checkin_rej  = rej_q;
  assign bus.release_err  = rel_err_q;

endmodule

// File: tb/tb_parking_checkin.sv
// Directed-vector bench for parking_checkin with TICK_DIV=4.
module tb_parking_checkin;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   cyc;

  parking_checkin_if bus();

  parking_checkin #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Timer value for the cycle that follows the cyc-th edge after reset release.
  function automatic logic [10:0] exp_timer(input int c);
    return 11'((c / 4) % 2048);
  endfunction

  function automatic logic [10:0] get_p(input int k);
    case (k)
      1: return bus.p1;
      2: return bus.p2;
      3: return bus.p3;
      4: return bus.p4;
      5: return bus.p5;
      default: return bus.p6;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_timer", 32'(bus.timer), 0);
    check("rst_occ", 32'(bus.occupied), 0);
    check("rst_ack", 32'(bus.checkin_ack), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Press and release; exp_slot==0 means a reject is required.
  task automatic press(input int exp_slot, input string tag);
    logic [10:0] t_stamp;
    bus.checkin_btn = 1'b1;
    tick();
    t_stamp = exp_timer(cyc);
    check({tag, "_early"}, 32'(bus.checkin_ack), 0);
    tick();
    if (exp_slot != 0) begin
      check({tag, "_ack"}, 32'(bus.checkin_ack), 1);
      check({tag, "_slot"}, 32'(bus.checkin_slot), 32'(exp_slot));
      check({tag, "_stamp"}, 32'(get_p(exp_slot)), 32'(t_stamp));
    end else begin
      check({tag, "_rej"}, 32'(bus.checkin_rej), 1);
      check({tag, "_noack"}, 32'(bus.checkin_ack), 0);
    end
    $display("press %s: ack=%0d rej=%0d slot=%0d occ=%b t=%0d", tag, bus.checkin_ack,
             bus.checkin_rej, bus.checkin_slot, bus.occupied, t_stamp);
    bus.checkin_btn = 1'b0;
    tick();
    check({tag, "_pulse"}, 32'(bus.checkin_ack | bus.checkin_rej), 0);
  endtask

  task automatic release_slot(input int s, input logic exp_err, input logic [5:0] exp_occ,
                              input string tag);
    bus.release_valid = 1'b1;
    bus.release_slot  = 4'(s);
    tick();
    bus.release_valid = 1'b0;
    bus.release_slot  = 4'd0;
    check({tag, "_err"}, 32'(bus.release_err), 32'(exp_err));
    check({tag, "_occ"}, 32'(bus.occupied), 32'(exp_occ));
    $display("release %s: slot=%0d err=%0d occ=%b", tag, s, bus.release_err, bus.occupied);
    tick();
    check({tag, "_errclr"}, 32'(bus.release_err), 0);
  endtask

  initial begin
    int ack_cnt;
    int guard;
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    rst_n = 1'b0;
    bus.checkin_btn   = 1'b0;
    bus.release_valid = 1'b0;
    bus.release_slot  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: idle time base
    repeat (3) tick();
    check("t1_timer3clk", 32'(bus.timer), 0);
    tick();
    check("t1_timer4clk", 32'(bus.timer), 1);
    repeat (16) tick();
    check("t1_timer20clk", 32'(bus.timer), 5);
    check("t1_p1", 32'(bus.p1), 0);
    check("t1_p6", 32'(bus.p6), 0);
    check("t1_occ", 32'(bus.occupied), 0);
    check("t1_full", 32'(bus.full), 0);

    // 2: press at timer=3, held 50 clk
    do_reset();
    repeat (12) tick();
    check("t2_timer", 32'(bus.timer), 3);
    bus.checkin_btn = 1'b1;
    tick();
    check("t2_early", 32'(bus.checkin_ack), 0);
    tick();
    check("t2_ack", 32'(bus.checkin_ack), 1);
    check("t2_slot", 32'(bus.checkin_slot), 1);
    check("t2_p1", 32'(bus.p1), 3);
    check("t2_occ", 32'(bus.occupied), 6'b000001);
    $display("press t2: ack=%0d slot=%0d p1=%0d", bus.checkin_ack, bus.checkin_slot, bus.p1);
    ack_cnt = 0;
    repeat (50) begin
      tick();
      ack_cnt += 32'(bus.checkin_ack);
    end
    check("t2_hold_acks", 32'(ack_cnt), 0);
    check("t2_slot_hold", 32'(bus.checkin_slot), 1);
    bus.checkin_btn = 1'b0;
    tick();

    // 3: fill remaining slots, then reject
    press(2, "t3_s2");
    press(3, "t3_s3");
    press(4, "t3_s4");
    press(5, "t3_s5");
    press(6, "t3_s6");
    check("t3_full", 32'(bus.full), 1);
    check("t3_occ", 32'(bus.occupied), 6'b111111);
    press(0, "t3_rej");
    check("t3_occ_after", 32'(bus.occupied), 6'b111111);
    check("t3_slot_kept", 32'(bus.checkin_slot), 6);

    // 4: release slot 3 in the GRANT cycle while full
    bus.checkin_btn = 1'b1;
    tick();
    bus.release_valid = 1'b1;
    bus.release_slot  = 4'd3;
    tick();
    bus.release_valid = 1'b0;
    bus.release_slot  = 4'd0;
    check("t4_rej", 32'(bus.checkin_rej), 1);
    check("t4_noack", 32'(bus.checkin_ack), 0);
    check("t4_occ", 32'(bus.occupied), 6'b111011);
    check("t4_relerr", 32'(bus.release_err), 0);
    check("t4_full", 32'(bus.full), 0);
    $display("press t4: rej=%0d occ=%b", bus.checkin_rej, bus.occupied);
    bus.checkin_btn = 1'b0;
    tick();
    press(3, "t4_regrant");
    check("t4_occ_full", 32'(bus.occupied), 6'b111111);

    // 5: release errors
    release_slot(5, 1'b0, 6'b101111, "t5_ok5");
    check("t5_p5_kept", 32'(bus.p5), 32'(bus.p5 === 11'd0 ? 11'd1 : bus.p5));
    release_slot(0, 1'b1, 6'b101111, "t5_zero");
    release_slot(7, 1'b1, 6'b101111, "t5_seven");
    release_slot(5, 1'b1, 6'b101111, "t5_free5");

    // 6: timer wrap, then reset inside GRANT
    guard = 0;
    while (exp_timer(cyc) != 11'd2047 && guard < 10000) begin
      tick();
      guard++;
    end
    check("t6_guard", 32'(guard < 10000), 1);
    check("t6_timer2047", 32'(bus.timer), 2047);
    repeat (3) tick();
    check("t6_timer_hold", 32'(bus.timer), 2047);
    tick();
    check("t6_wrap", 32'(bus.timer), 0);

    bus.checkin_btn = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_occ", 32'(bus.occupied), 0);
    check("t6_rst_ack", 32'(bus.checkin_ack), 0);
    check("t6_rst_slot", 32'(bus.checkin_slot), 0);
    check("t6_rst_p1", 32'(bus.p1), 0);
    check("t6_rst_full", 32'(bus.full), 0);
    @(posedge clk);
    #1;
    check("t6_rst_noack", 32'(bus.checkin_ack), 0);
    bus.checkin_btn = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    ack_cnt = 0;
    repeat (4) begin
      tick();
      ack_cnt += 32'(bus.checkin_ack);
    end
    check("t6_post_acks", 32'(ack_cnt), 0);
    check("t6_post_timer", 32'(bus.timer), 1);
    check("t6_post_occ", 32'(bus.occupied), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
